// File: rtl/vrf_bank_wr_if.sv
// Write/read bus for one vector register file bank. The upstream
// write-select stage and the read clients drive the master side; the bank
// itself sits on the slave side.
interface vrf_bank_wr_if #(
  parameter int NUM_RD_PORTS = 8,
  parameter int DATA_SIZE    = 2048,
  parameter int NUM_REGS     = 32
);
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NUM_BYTES = DATA_SIZE / 8;

  logic                 match_found;
  logic [DATA_SIZE-1:0] win_wr_data;
  logic [NUM_BYTES-1:0] win_wr_strb;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 wr_ack;

  logic                 rd_en    [NUM_RD_PORTS];
  logic [ADDR_W-1:0]    rd_addr  [NUM_RD_PORTS];
  logic [DATA_SIZE-1:0] rd_data  [NUM_RD_PORTS];
  logic                 rd_valid [NUM_RD_PORTS];

  modport master (
    output match_found, win_wr_data, win_wr_strb, wr_addr, rd_en, rd_addr,
    input  wr_ack, rd_data, rd_valid
  );

  modport slave (
    input  match_found, win_wr_data, win_wr_strb, wr_addr, rd_en, rd_addr,
    output wr_ack, rd_data, rd_valid
  );
endinterface

// File: rtl/vrf_bank_wr.sv
// One bank of the vector register file: a two-stage byte-strobed write path
// (capture, then commit) and NUM_RD_PORTS independent registered read ports.
// Optional macro VRF_WR_BYPASS_EN forwards a pending write into a read of the
// same register on the commit edge; without it reads see pre-commit contents.
module vrf_bank_wr #(
  parameter int NUM_RD_PORTS = 8,
  parameter int DATA_SIZE    = 2048,
  parameter int NUM_REGS     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  vrf_bank_wr_if.slave bus
);
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NUM_BYTES = DATA_SIZE / 8;

  logic [DATA_SIZE-1:0] mem [NUM_REGS];

  logic                 pend_vld;
  logic [DATA_SIZE-1:0] pend_data;
  logic [NUM_BYTES-1:0] pend_strb;
  logic [ADDR_W-1:0]    pend_addr;

  logic [DATA_SIZE-1:0] rd_src [NUM_RD_PORTS];

  // The ack is the pending flag itself, so it is high in the cycle before commit.
  assign bus.wr_ack = pend_vld;

  // Stage 1: capture the winner write; the pending flag only lives one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
      pend_strb <= '0;
      pend_addr <= '0;
    end else begin
      pend_vld <= bus.match_found;
      if (bus.match_found) begin
        pend_data <= bus.win_wr_data;
        pend_strb <= bus.win_wr_strb;
        pend_addr <= bus.wr_addr;
      end
    end
  end

  // Stage 2: commit strobed bytes; addresses beyond NUM_REGS match no row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else if (pend_vld) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (pend_addr == ADDR_W'(r)) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (pend_strb[b]) begin
              mem[r][b*8 +: 8] <= pend_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Per-port read mux; an address with no matching row yields zeros.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_src[p] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (bus.rd_addr[p] == ADDR_W'(r)) begin
          rd_src[p] = mem[r];
`ifdef VRF_WR_BYPASS_EN
          if (pend_vld && (pend_addr == ADDR_W'(r))) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
              if (pend_strb[b]) begin
                rd_src[p][b*8 +: 8] = pend_data[b*8 +: 8];
              end
            end
          end
`endif
        end
      end
    end
  end

  // Read registers: load on request, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        bus.rd_data[p]  <= '0;
        bus.rd_valid[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        bus.rd_valid[p] <= bus.rd_en[p];
        if (bus.rd_en[p]) begin
          bus.rd_data[p] <= rd_src[p];
        end
      end
    end
  end
endmodule

// File: tb/tb_vrf_bank_wr.sv
// Directed bench for vrf_bank_wr using a small configuration: 64-bit
// registers, 24 registers (so addresses 24..31 are out of range), 4 ports.
module tb_vrf_bank_wr;
  localparam int NP = 4;
  localparam int DS = 64;
  localparam int NR = 24;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad = 0;

  vrf_bank_wr_if #(.NUM_RD_PORTS(NP), .DATA_SIZE(DS), .NUM_REGS(NR)) bus();

  vrf_bank_wr #(.NUM_RD_PORTS(NP), .DATA_SIZE(DS), .NUM_REGS(NR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.match_found = 1'b0;
    bus.win_wr_data = '0;
    bus.win_wr_strb = '0;
    bus.wr_addr     = '0;
    for (int p = 0; p < NP; p++) begin
      bus.rd_en[p]   = 1'b0;
      bus.rd_addr[p] = '0;
    end
  endtask

  task automatic set_write(input logic [AW-1:0] a, input logic [DS-1:0] d,
                           input logic [DS/8-1:0] s);
    bus.match_found = 1'b1;
    bus.wr_addr     = a;
    bus.win_wr_data = d;
    bus.win_wr_strb = s;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (bus.wr_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ack got=%b want=0", bus.wr_ack);
    end
    for (int p = 0; p < NP; p++) begin
      total++;
      if (bus.rd_valid[p] !== 1'b0 || bus.rd_data[p] !== 64'h0) begin
        bad++;
        $display("[TB] FAIL reset_rd p=%0d valid=%b data=%h want 0/0", p,
                 bus.rd_valid[p], bus.rd_data[p]);
      end
    end
    #10 rst_n = 1'b1;
    for (int p = 0; p < NP; p++) bus.rd_en[p] = 1'b1;
    tick();
    idle_inputs();
    for (int p = 0; p < NP; p++) begin
      total++;
      if (bus.rd_valid[p] !== 1'b1 || bus.rd_data[p] !== 64'h0) begin
        bad++;
        $display("[TB] FAIL reset_read p=%0d valid=%b data=%h want 1/0", p,
                 bus.rd_valid[p], bus.rd_data[p]);
      end
    end
    total++;
    if (bus.wr_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_read_ack got=%b want=0", bus.wr_ack);
    end
  endtask

  task automatic test_full_write();
    logic [DS-1:0] held;
    set_write(5'd3, {8{8'hA5}}, 8'hFF);
    tick();
    idle_inputs();
    total++;
    if (bus.wr_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_ack_hi got=%b want=1", bus.wr_ack);
    end
    tick();
    total++;
    if (bus.wr_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_ack_lo got=%b want=0", bus.wr_ack);
    end
    bus.rd_en[0]   = 1'b1;
    bus.rd_addr[0] = 5'd3;
    tick();
    bus.rd_en[0] = 1'b0;
    total++;
    if (bus.rd_data[0] !== {8{8'hA5}} || bus.rd_valid[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_read got=%h/%b want=%h/1", bus.rd_data[0],
               bus.rd_valid[0], {8{8'hA5}});
    end
    held = bus.rd_data[0];
    bus.rd_addr[0] = 5'd0;
    tick();
    total++;
    if (bus.rd_valid[0] !== 1'b0 || bus.rd_data[0] !== 64'hA5A5A5A5A5A5A5A5) begin
      bad++;
      $display("[TB] FAIL read_hold got=%h/%b want=%h/0", bus.rd_data[0],
               bus.rd_valid[0], held);
    end
  endtask

  task automatic test_strobe();
    set_write(5'd5, {8{8'hFF}}, 8'h0F);
    tick();
    idle_inputs();
    tick();
    bus.rd_en[1]   = 1'b1;
    bus.rd_addr[1] = 5'd5;
    tick();
    idle_inputs();
    total++;
    if (bus.rd_data[1] !== 64'h00000000FFFFFFFF) begin
      bad++;
      $display("[TB] FAIL strobe_read got=%h want=00000000ffffffff", bus.rd_data[1]);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    set_write(5'd1, 64'd1, 8'hFF);
    tick();
    acks += int'(bus.wr_ack);
    set_write(5'd2, 64'd2, 8'hFF);
    tick();
    acks += int'(bus.wr_ack);
    set_write(5'd3, 64'd3, 8'hFF);
    tick();
    acks += int'(bus.wr_ack);
    idle_inputs();
    tick();
    acks += int'(bus.wr_ack);
    tick();
    acks += int'(bus.wr_ack);
    total++;
    if (acks != 3) begin
      bad++;
      $display("[TB] FAIL b2b_acks got=%0d want=3", acks);
    end
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = 5'd1;
    bus.rd_en[1] = 1'b1; bus.rd_addr[1] = 5'd2;
    bus.rd_en[2] = 1'b1; bus.rd_addr[2] = 5'd3;
    bus.rd_en[3] = 1'b1; bus.rd_addr[3] = 5'd2;
    tick();
    idle_inputs();
    total++;
    if (bus.rd_data[0] !== 64'd1 || bus.rd_data[1] !== 64'd2 ||
        bus.rd_data[2] !== 64'd3 || bus.rd_data[3] !== 64'd2) begin
      bad++;
      $display("[TB] FAIL b2b_read got=%h %h %h %h want=1 2 3 2", bus.rd_data[0],
               bus.rd_data[1], bus.rd_data[2], bus.rd_data[3]);
    end
  endtask

  task automatic test_zero_strobe_and_range();
    set_write(5'd3, 64'h0123456789ABCDEF, 8'h00);
    tick();
    idle_inputs();
    total++;
    if (bus.wr_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL zero_strb_ack got=%b want=1", bus.wr_ack);
    end
    tick();
    set_write(5'd25, 64'hDEADBEEFDEADBEEF, 8'hFF);
    tick();
    idle_inputs();
    total++;
    if (bus.wr_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oor_wr_ack got=%b want=1", bus.wr_ack);
    end
    tick();
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = 5'd3;
    bus.rd_en[1] = 1'b1; bus.rd_addr[1] = 5'd25;
    bus.rd_en[2] = 1'b1; bus.rd_addr[2] = 5'd9;
    bus.rd_en[3] = 1'b1; bus.rd_addr[3] = 5'd1;
    tick();
    idle_inputs();
    total++;
    if (bus.rd_data[0] !== 64'd3) begin
      bad++;
      $display("[TB] FAIL zero_strb_read got=%h want=3", bus.rd_data[0]);
    end
    total++;
    if (bus.rd_data[1] !== 64'h0 || bus.rd_valid[1] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oor_read got=%h/%b want=0/1", bus.rd_data[1], bus.rd_valid[1]);
    end
    total++;
    if (bus.rd_data[2] !== 64'h0 || bus.rd_data[3] !== 64'd1) begin
      bad++;
      $display("[TB] FAIL oor_no_alias got=%h %h want=0 1", bus.rd_data[2], bus.rd_data[3]);
    end
  endtask

  task automatic test_commit_collision();
    logic [DS-1:0] exp_edge;
`ifdef VRF_WR_BYPASS_EN
    exp_edge = {8{8'h11}};
`else
    exp_edge = {8{8'h22}};
`endif
    set_write(5'd7, {8{8'h22}}, 8'hFF);
    tick();
    idle_inputs();
    tick();
    set_write(5'd7, {8{8'h11}}, 8'hFF);
    tick();
    idle_inputs();
    bus.rd_en[2] = 1'b1; bus.rd_addr[2] = 5'd7;
    tick();
    total++;
    if (bus.rd_data[2] !== exp_edge) begin
      bad++;
      $display("[TB] FAIL commit_edge_read got=%h want=%h", bus.rd_data[2], exp_edge);
    end
    tick();
    bus.rd_en[2] = 1'b0;
    total++;
    if (bus.rd_data[2] !== {8{8'h11}}) begin
      bad++;
      $display("[TB] FAIL post_commit_read got=%h want=%h", bus.rd_data[2], {8{8'h11}});
    end
    set_write(5'd8, {8{8'h33}}, 8'hFF);
    bus.rd_en[3] = 1'b1; bus.rd_addr[3] = 5'd8;
    tick();
    idle_inputs();
    total++;
    if (bus.rd_data[3] !== 64'h0) begin
      bad++;
      $display("[TB] FAIL capture_edge_read got=%h want=0", bus.rd_data[3]);
    end
    tick();
  endtask

  task automatic test_reset_pending();
    int acks = 0;
    set_write(5'd4, {8{8'h44}}, 8'hFF);
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.wr_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_pend_ack got=%b want=0", bus.wr_ack);
    end
    rst_n = 1'b1;
    tick();
    acks += int'(bus.wr_ack);
    tick();
    acks += int'(bus.wr_ack);
    total++;
    if (acks != 0) begin
      bad++;
      $display("[TB] FAIL rst_pend_late_ack got=%0d want=0", acks);
    end
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = 5'd4;
    bus.rd_en[1] = 1'b1; bus.rd_addr[1] = 5'd7;
    tick();
    idle_inputs();
    total++;
    if (bus.rd_data[0] !== 64'h0 || bus.rd_data[1] !== 64'h0) begin
      bad++;
      $display("[TB] FAIL rst_pend_read got=%h %h want=0 0", bus.rd_data[0], bus.rd_data[1]);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_strobe();
    test_back_to_back();
    test_zero_strobe_and_range();
    test_commit_collision();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vrf_bank_wr.md
VRF_BANK_WR -- requirements
Module: vrf_bank_wr

Interface
REQ-001 SHALL have parameter NUM_RD_PORTS, default 8: number of independent read ports.
REQ-002 SHALL have parameter DATA_SIZE, default 2048: vector register width in bits; a multiple of 8.
REQ-003 SHALL have parameter NUM_REGS, default 32: registers per bank; ADDR_W = clog2(NUM_REGS), minimum 1.
REQ-004 SHALL have port clk  input  1: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port match_found  input  1: winner write valid from the upstream write-select stage.
REQ-007 SHALL have port win_wr_data  input  DATA_SIZE: winner write data.
REQ-008 SHALL have port win_wr_strb  input  DATA_SIZE/8: winner byte strobe; bit b covers data bits [8b+7:8b].
REQ-009 SHALL have port wr_addr  input  ADDR_W: register index within this bank for the winner write.
REQ-010 SHALL have port rd_en  input  1 per read port (unpacked, NUM_RD_PORTS): read request.
REQ-011 SHALL have port rd_addr  input  ADDR_W per read port: read register index.
REQ-012 SHALL have port rd_data  output  DATA_SIZE per read port: registered read data.
REQ-013 SHALL have port rd_valid  output  1 per read port: rd_data valid this cycle.
REQ-014 SHALL have port wr_ack  output  1: one-cycle pulse in the cycle a write commits.

Function
REQ-015 Stage 1: on an edge where match_found=1, SHALL capture win_wr_data, win_wr_strb and wr_addr into a pending register and set pend_vld=1; otherwise SHALL clear pend_vld.
REQ-016 Stage 2: on the edge following capture, SHALL write each byte b of mem[pend_addr] with pend_strb[b]=1; bytes with strobe 0 SHALL retain their value.
REQ-017 wr_ack SHALL equal pend_vld, so it is high exactly one cycle per accepted write, in the cycle before the commit edge.
REQ-018 Back-to-back writes (match_found high every cycle) SHALL be accepted at one per cycle with no stall and no drops.
REQ-019 A write with all-zero strobe SHALL leave memory unchanged and still pulse wr_ack.
REQ-020 A write with pend_addr >= NUM_REGS SHALL be discarded without any memory change; wr_ack still pulses.
REQ-021 Read: on an edge where rd_en[p]=1, rd_data[p] SHALL load mem[rd_addr[p]] and rd_valid[p] SHALL be 1 the next cycle (latency 1).
REQ-022 When rd_en[p]=0, rd_valid[p] SHALL be 0 next cycle and rd_data[p] SHALL hold its last value.
REQ-023 An out-of-range rd_addr[p] SHALL return all zeros with rd_valid[p]=1.
REQ-024 All read ports SHALL operate independently; any number may read the same address in the same cycle.
REQ-025 A read sampled on the same edge as a commit to the same address SHALL return the pre-commit value (bypass disabled; see REQ-030).
REQ-026 A write captured on edge E SHALL never be visible to a read sampled on edge E.

Reset
REQ-027 rst_n low SHALL asynchronously clear pend_vld, wr_ack, every rd_valid, every rd_data and all NUM_REGS memory registers to zero.
REQ-028 A write pending when reset asserts SHALL be discarded; no commit SHALL occur after reset release for it.
REQ-029 The first write SHALL be capturable on the first rising edge with rst_n high.

Configuration
REQ-030 With macro VRF_WR_BYPASS_EN defined, a read sampled on the edge where pend_vld=1 and pend_addr==rd_addr[p] SHALL return the merged value (pending bytes where strobe=1, memory bytes elsewhere); without it, REQ-025 applies and no bypass logic SHALL be present.

Verification
REQ-031 Reset, then read all ports at addr 0 -> rd_data=0, rd_valid=1 one cycle later, wr_ack=0.
REQ-032 Write addr 3, data all 0xA5, strb all ones; read addr 3 two cycles after capture -> rd_data all 0xA5; wr_ack high exactly one cycle.
REQ-033 Prior contents 0x00; write addr 5 data all 0xFF with strb=0x...0F (bytes 0-3) -> read returns 0xFFFFFFFF in bits [31:0], zero elsewhere.
REQ-034 Writes to addr 1,2,3 on three consecutive cycles, data 1,2,3 -> each address reads its value; three wr_ack pulses.
REQ-035 Read addr 7 sampled on the commit edge of write 0x11 (all bytes) over prior 0x22 -> returns 0x22 without VRF_WR_BYPASS_EN, 0x11 with it.
REQ-036 Capture write to addr 4, assert rst_n low before commit edge -> addr 4 reads 0 after release; no wr_ack after release.
